// File: rtl/dram_id_remapper_pkg.sv
// Shared types and helpers for the DRAM-side AXI ID remapper.
package dram_id_remapper_pkg;

  localparam int unsigned SLV_ID_WIDTH    = 8;
  localparam int unsigned MST_ID_WIDTH    = 4;
  localparam int unsigned MAX_TXNS_PER_ID = 8;
  localparam int unsigned ADDR_WIDTH      = 32;
  localparam int unsigned DATA_WIDTH      = 32;

  // Narrow IDs already cover the wide ID space: no tables needed.
  localparam bit BYPASS = (SLV_ID_WIDTH <= MST_ID_WIDTH);

  // Counter width able to hold 0..max_txns inclusive.
  function automatic int unsigned cnt_width(input int unsigned max_txns);
    return $clog2(max_txns + 1);
  endfunction

  localparam int unsigned CNT_WIDTH = cnt_width(MAX_TXNS_PER_ID);

  // One remap table entry for the default configuration.
  typedef struct packed {
    logic [SLV_ID_WIDTH-1:0] slv_id;
    logic [CNT_WIDTH-1:0]    cnt;
  } tbl_entry_t;

  // ID-independent parts of the AXI channels, shared by both sides.
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
  } ax_payload_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0]   data;
    logic [DATA_WIDTH/8-1:0] strb;
    logic                    last;
  } w_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [1:0]            resp;
    logic                  last;
  } r_payload_t;

  typedef struct packed { logic [SLV_ID_WIDTH-1:0] id; ax_payload_t p; } slv_ax_t;
  typedef struct packed { logic [MST_ID_WIDTH-1:0] id; ax_payload_t p; } mst_ax_t;
  typedef struct packed { logic [SLV_ID_WIDTH-1:0] id; logic [1:0] resp; } slv_b_t;
  typedef struct packed { logic [MST_ID_WIDTH-1:0] id; logic [1:0] resp; } mst_b_t;
  typedef struct packed { logic [SLV_ID_WIDTH-1:0] id; r_payload_t p; } slv_r_t;
  typedef struct packed { logic [MST_ID_WIDTH-1:0] id; r_payload_t p; } mst_r_t;

  typedef struct packed {
    slv_ax_t aw; logic aw_valid;
    w_t      w;  logic w_valid;
    logic    b_ready;
    slv_ax_t ar; logic ar_valid;
    logic    r_ready;
  } slv_req_t;

  typedef struct packed {
    logic   aw_ready;
    logic   w_ready;
    slv_b_t b; logic b_valid;
    logic   ar_ready;
    slv_r_t r; logic r_valid;
  } slv_rsp_t;

  typedef struct packed {
    mst_ax_t aw; logic aw_valid;
    w_t      w;  logic w_valid;
    logic    b_ready;
    mst_ax_t ar; logic ar_valid;
    logic    r_ready;
  } mst_req_t;

  typedef struct packed {
    logic   aw_ready;
    logic   w_ready;
    mst_b_t b; logic b_valid;
    logic   ar_ready;
    mst_r_t r; logic r_valid;
  } mst_rsp_t;

endpackage

// File: rtl/dram_id_remap_table.sv
// One direction's remap table: wide ID -> narrow index, with per-entry
// outstanding-transaction counters.
module dram_id_remap_table
  import dram_id_remapper_pkg::*;
#(
  parameter int unsigned SlvIdWidth   = SLV_ID_WIDTH,
  parameter int unsigned MstIdWidth   = MST_ID_WIDTH,
  parameter int unsigned MaxTxnsPerId = MAX_TXNS_PER_ID
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [SlvIdWidth-1:0] i_lookup_id,
  input  logic                  i_alloc,
  input  logic                  i_free,
  input  logic [MstIdWidth-1:0] i_free_idx,
  output logic                  o_avail,
  output logic [MstIdWidth-1:0] o_idx,
  output logic [SlvIdWidth-1:0] o_rsp_slv_id
);

  localparam int unsigned NumEntries = 2 ** MstIdWidth;
  localparam int unsigned CntWidth   = cnt_width(MaxTxnsPerId);
  localparam logic [CntWidth-1:0] CntMax = CntWidth'(MaxTxnsPerId);
  localparam logic [CntWidth-1:0] CntOne = CntWidth'(1);

  typedef struct packed {
    logic [SlvIdWidth-1:0] slv_id;
    logic [CntWidth-1:0]   cnt;
  } entry_t;

  entry_t                  r_tbl [NumEntries];
  logic                    w_match;
  logic                    w_free_found;
  logic [MstIdWidth-1:0]   w_match_idx;
  logic [MstIdWidth-1:0]   w_free_idx;
  logic [NumEntries-1:0]   w_inc;
  logic [NumEntries-1:0]   w_dec;

  // Lookup on registered state: live matching entry, else lowest free entry.
  always_comb begin
    // NOTE: every variable gets a default before the loop so no latch is inferred.
    w_match      = 1'b0;
    w_match_idx  = '0;
    w_free_found = 1'b0;
    w_free_idx   = '0;
    // Descending scan so the last hit written is the lowest index.
    for (int e = int'(NumEntries) - 1; e >= 0; e--) begin
      if (r_tbl[e].cnt != '0 && r_tbl[e].slv_id == i_lookup_id) begin
        w_match     = 1'b1;
        w_match_idx = MstIdWidth'(e);
      end
      if (r_tbl[e].cnt == '0) begin
        w_free_found = 1'b1;
        w_free_idx   = MstIdWidth'(e);
      end
    end
    // A saturated match stalls; it never spills into a second entry.
    o_avail = w_match ? (r_tbl[w_match_idx].cnt != CntMax) : w_free_found;
    o_idx   = w_match ? w_match_idx : w_free_idx;
  end

  // Response path returns whatever wide ID the named entry holds.
  assign o_rsp_slv_id = r_tbl[i_free_idx].slv_id;

  // Per-entry increment/decrement strobes; a free of an idle entry is ignored.
  always_comb begin
    for (int e = 0; e < int'(NumEntries); e++) begin
      w_inc[e] = i_alloc && (o_idx == MstIdWidth'(e));
      w_dec[e] = i_free && (i_free_idx == MstIdWidth'(e)) && (r_tbl[e].cnt != '0);
    end
  end

  // Table state: counters move by inc - dec, new owners latch the wide ID.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: this table is control state (free/busy), so it is reset unlike a data RAM.
      for (int e = 0; e < int'(NumEntries); e++) r_tbl[e] <= '0;
    end else begin
      for (int e = 0; e < int'(NumEntries); e++) begin
        // NOTE: non-blocking so all entries update from the same pre-edge snapshot.
        if (w_inc[e] && !w_dec[e]) begin
          r_tbl[e].cnt    <= r_tbl[e].cnt + CntOne;
          r_tbl[e].slv_id <= i_lookup_id;
        end else if (!w_inc[e] && w_dec[e]) begin
          r_tbl[e].cnt    <= r_tbl[e].cnt - CntOne;
        end
      end
    end
  end

  // A response for an entry with nothing outstanding is a controller protocol error.
  a_free_of_idle_entry: assert property (
    @(posedge clk) disable iff (!rst_n) i_free |-> (r_tbl[i_free_idx].cnt != '0));

endmodule

// File: rtl/dram_id_remapper.sv
// AXI4 ID-width reducer in front of the DRAM controller slave port.
// Data path is combinational; only the remap tables hold state.
module dram_id_remapper #(
  parameter int unsigned SlvIdWidth   = dram_id_remapper_pkg::SLV_ID_WIDTH,
  parameter int unsigned MstIdWidth   = dram_id_remapper_pkg::MST_ID_WIDTH,
  parameter int unsigned MaxTxnsPerId = dram_id_remapper_pkg::MAX_TXNS_PER_ID,
  parameter type slv_req_t = dram_id_remapper_pkg::slv_req_t,
  parameter type slv_rsp_t = dram_id_remapper_pkg::slv_rsp_t,
  parameter type mst_req_t = dram_id_remapper_pkg::mst_req_t,
  parameter type mst_rsp_t = dram_id_remapper_pkg::mst_rsp_t
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  slv_req_t slv_req_i,
  output slv_rsp_t slv_rsp_o,
  output mst_req_t mst_req_o,
  input  mst_rsp_t mst_rsp_i
);

  logic                  w_ar_avail;
  logic                  w_aw_avail;
  logic [MstIdWidth-1:0] w_ar_idx;
  logic [MstIdWidth-1:0] w_aw_idx;
  logic [SlvIdWidth-1:0] w_r_slv_id;
  logic [SlvIdWidth-1:0] w_b_slv_id;

  if (SlvIdWidth <= MstIdWidth) begin : g_bypass
    assign w_ar_avail = 1'b1;
    assign w_aw_avail = 1'b1;
    assign w_ar_idx   = MstIdWidth'(slv_req_i.ar.id);
    assign w_aw_idx   = MstIdWidth'(slv_req_i.aw.id);
    assign w_r_slv_id = SlvIdWidth'(mst_rsp_i.r.id);
    assign w_b_slv_id = SlvIdWidth'(mst_rsp_i.b.id);
  end else begin : g_remap
    logic w_ar_hs, w_aw_hs, w_r_last_hs, w_b_hs;

    assign w_ar_hs     = slv_req_i.ar_valid && mst_rsp_i.ar_ready && w_ar_avail;
    assign w_aw_hs     = slv_req_i.aw_valid && mst_rsp_i.aw_ready && w_aw_avail;
    assign w_r_last_hs = mst_rsp_i.r_valid && slv_req_i.r_ready && mst_rsp_i.r.p.last;
    assign w_b_hs      = mst_rsp_i.b_valid && slv_req_i.b_ready;

    dram_id_remap_table #(
      .SlvIdWidth(SlvIdWidth), .MstIdWidth(MstIdWidth), .MaxTxnsPerId(MaxTxnsPerId)
    ) u_rd_table (
      .clk(clk_i), .rst_n(rst_ni),
      .i_lookup_id(slv_req_i.ar.id), .i_alloc(w_ar_hs),
      .i_free(w_r_last_hs), .i_free_idx(mst_rsp_i.r.id),
      .o_avail(w_ar_avail), .o_idx(w_ar_idx), .o_rsp_slv_id(w_r_slv_id)
    );

    dram_id_remap_table #(
      .SlvIdWidth(SlvIdWidth), .MstIdWidth(MstIdWidth), .MaxTxnsPerId(MaxTxnsPerId)
    ) u_wr_table (
      .clk(clk_i), .rst_n(rst_ni),
      .i_lookup_id(slv_req_i.aw.id), .i_alloc(w_aw_hs),
      .i_free(w_b_hs), .i_free_idx(mst_rsp_i.b.id),
      .o_avail(w_aw_avail), .o_idx(w_aw_idx), .o_rsp_slv_id(w_b_slv_id)
    );
  end

  // Forward all channels, swapping IDs and gating address handshakes on avail.
  always_comb begin
    mst_req_o          = '0;
    mst_req_o.aw.id    = w_aw_idx;
    mst_req_o.aw.p     = slv_req_i.aw.p;
    mst_req_o.aw_valid = slv_req_i.aw_valid && w_aw_avail;
    mst_req_o.w        = slv_req_i.w;
    mst_req_o.w_valid  = slv_req_i.w_valid;
    mst_req_o.b_ready  = slv_req_i.b_ready;
    mst_req_o.ar.id    = w_ar_idx;
    mst_req_o.ar.p     = slv_req_i.ar.p;
    mst_req_o.ar_valid = slv_req_i.ar_valid && w_ar_avail;
    mst_req_o.r_ready  = slv_req_i.r_ready;

    slv_rsp_o          = '0;
    slv_rsp_o.aw_ready = mst_rsp_i.aw_ready && w_aw_avail;
    slv_rsp_o.w_ready  = mst_rsp_i.w_ready;
    slv_rsp_o.b.id     = w_b_slv_id;
    slv_rsp_o.b.resp   = mst_rsp_i.b.resp;
    slv_rsp_o.b_valid  = mst_rsp_i.b_valid;
    slv_rsp_o.ar_ready = mst_rsp_i.ar_ready && w_ar_avail;
    slv_rsp_o.r.id     = w_r_slv_id;
    slv_rsp_o.r.p      = mst_rsp_i.r.p;
    slv_rsp_o.r_valid  = mst_rsp_i.r_valid;
  end

endmodule

// File: tb/tb_dram_id_remapper.sv
// Directed and randomized checks for the DRAM AXI ID remapper.
module tb_dram_id_remapper;
  import dram_id_remapper_pkg::*;

  logic     clk = 1'b0;
  logic     rst_n;
  slv_req_t slv_req;
  slv_rsp_t slv_rsp;
  mst_req_t mst_req;
  mst_rsp_t mst_rsp;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [MST_ID_WIDTH-1:0] mid;
    logic [SLV_ID_WIDTH-1:0] sid;
    logic [31:0]             addr;
  } txn_t;

  always #5 clk = ~clk;

  dram_id_remapper dut (
    .clk_i(clk), .rst_ni(rst_n),
    .slv_req_i(slv_req), .slv_rsp_o(slv_rsp),
    .mst_req_o(mst_req), .mst_rsp_i(mst_rsp)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive_ar(input logic [7:0] id, input logic [31:0] addr);
    slv_req.ar_valid  = 1'b1;
    slv_req.ar.id     = id;
    slv_req.ar.p.addr = addr;
    slv_req.ar.p.len  = 8'd0;
  endtask

  task automatic drive_r(input logic [3:0] id, input logic last, input logic [31:0] data);
    mst_rsp.r_valid  = 1'b1;
    mst_rsp.r.id     = id;
    mst_rsp.r.p.last = last;
    mst_rsp.r.p.data = data;
    mst_rsp.r.p.resp = 2'b00;
  endtask

  task automatic clear_valids();
    slv_req.ar_valid = 1'b0;
    slv_req.aw_valid = 1'b0;
    slv_req.w_valid  = 1'b0;
    mst_rsp.r_valid  = 1'b0;
    mst_rsp.b_valid  = 1'b0;
  endtask

  initial begin
    txn_t        q[$];
    int          beat;
    logic        pending;
    logic [7:0]  cur_id;
    logic [31:0] cur_addr;

    slv_req = '0;
    mst_rsp = '0;
    mst_rsp.ar_ready = 1'b1;
    mst_rsp.aw_ready = 1'b1;
    mst_rsp.w_ready  = 1'b1;
    slv_req.r_ready  = 1'b1;
    slv_req.b_ready  = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    settle();

    // Reset state
    check("rst_ar_ready", slv_rsp.ar_ready, 1);
    check("rst_aw_ready", slv_rsp.aw_ready, 1);
    check("rst_ar_valid", mst_req.ar_valid, 0);

    // Single read round trip
    drive_ar(8'h5A, 32'h1000);
    settle();
    check("t1_arid", mst_req.ar.id, 0);
    check("t1_arvalid", mst_req.ar_valid, 1);
    check("t1_araddr", mst_req.ar.p.addr, 32'h1000);
    mst_rsp.ar_ready = 1'b0;
    settle();
    check("t1_ready_gated", slv_rsp.ar_ready, 0);
    mst_rsp.ar_ready = 1'b1;
    tick();
    slv_req.ar_valid = 1'b0;
    drive_r(4'd0, 1'b1, 32'hDEADBEEF);
    settle();
    check("t1_rid", slv_rsp.r.id, 8'h5A);
    check("t1_rdata", slv_rsp.r.p.data, 32'hDEADBEEF);
    check("t1_rready_fwd", mst_req.r_ready, 1);
    tick();
    mst_rsp.r_valid = 1'b0;
    drive_ar(8'h33, 32'h0);
    settle();
    check("t1_entry0_freed", mst_req.ar.id, 0);
    slv_req.ar_valid = 1'b0;

    // Saturate one entry with eight same-ID reads
    for (int i = 0; i < 8; i++) begin
      drive_ar(8'h11, 32'h2000 + 32'(i * 64));
      settle();
      check("t2_arid", mst_req.ar.id, 0);
      tick();
    end
    drive_ar(8'h11, 32'h3000);
    settle();
    check("t2_stall_ready", slv_rsp.ar_ready, 0);
    check("t2_stall_valid", mst_req.ar_valid, 0);
    tick();
    check("t2_stall_hold", slv_rsp.ar_ready, 0);
    drive_r(4'd0, 1'b1, 32'h0);
    settle();
    check("t2_rid_sat", slv_rsp.r.id, 8'h11);
    check("t2_free_not_same_cycle", slv_rsp.ar_ready, 0);
    tick();
    mst_rsp.r_valid = 1'b0;
    settle();
    check("t2_unstall_ready", slv_rsp.ar_ready, 1);
    check("t2_unstall_id", mst_req.ar.id, 0);
    tick();
    drive_ar(8'h44, 32'h0);
    settle();
    check("t2_other_id", mst_req.ar.id, 1);
    slv_req.ar_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive_r(4'd0, 1'b1, 32'h0);
      settle();
      check("t2_drain_rid", slv_rsp.r.id, 8'h11);
      tick();
    end
    mst_rsp.r_valid = 1'b0;

    // W pass-through, then fill the write table
    slv_req.w_valid = 1'b1;
    slv_req.w.data  = 32'hCAFEF00D;
    slv_req.w.strb  = 4'hF;
    slv_req.w.last  = 1'b1;
    settle();
    check("t3_wdata", mst_req.w.data, 32'hCAFEF00D);
    check("t3_wvalid", mst_req.w_valid, 1);
    check("t3_wready", slv_rsp.w_ready, 1);
    slv_req.w_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      slv_req.aw_valid = 1'b1;
      slv_req.aw.id    = 8'(8'h80 + i);
      settle();
      check("t3_awid", mst_req.aw.id, 64'(i));
      tick();
    end
    slv_req.aw.id = 8'h90;
    settle();
    check("t3_full_ready", slv_rsp.aw_ready, 0);
    check("t3_full_valid", mst_req.aw_valid, 0);
    mst_rsp.b_valid = 1'b1;
    mst_rsp.b.id    = 4'd3;
    settle();
    check("t3_bid", slv_rsp.b.id, 8'h83);
    check("t3_bready_fwd", mst_req.b_ready, 1);
    check("t3_still_full", slv_rsp.aw_ready, 0);
    tick();
    mst_rsp.b_valid = 1'b0;
    settle();
    check("t3_realloc_ready", slv_rsp.aw_ready, 1);
    check("t3_realloc_id", mst_req.aw.id, 3);
    tick();
    slv_req.aw_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      mst_rsp.b_valid = 1'b1;
      mst_rsp.b.id    = 4'(i);
      settle();
      check("t3_drain_bid", slv_rsp.b.id, (i == 3) ? 64'h90 : 64'(8'h80 + i));
      tick();
    end
    mst_rsp.b_valid = 1'b0;

    // Simultaneous allocate and free on the same entry
    drive_ar(8'hA0, 32'h0); tick();
    drive_ar(8'hA1, 32'h0); tick();
    drive_ar(8'h22, 32'h0); settle();
    check("t4_alloc2", mst_req.ar.id, 2);
    tick();
    drive_r(4'd2, 1'b1, 32'h0);
    settle();
    check("t4_same_id", mst_req.ar.id, 2);
    check("t4_same_rid", slv_rsp.r.id, 8'h22);
    tick();
    mst_rsp.r_valid = 1'b0;
    drive_ar(8'h66, 32'h0);
    settle();
    check("t4_entry2_busy", mst_req.ar.id, 3);
    slv_req.ar_valid = 1'b0;
    drive_r(4'd2, 1'b1, 32'h0);
    settle();
    check("t4_slv_id_kept", slv_rsp.r.id, 8'h22);
    tick();
    mst_rsp.r_valid = 1'b0;
    drive_ar(8'h55, 32'h0);
    settle();
    check("t4_entry2_free", mst_req.ar.id, 2);
    slv_req.ar_valid = 1'b0;

    // Interleaved beats on entries 0 and 1
    for (int i = 0; i < 4; i++) begin
      drive_r(4'(i % 2), 1'b0, 32'(i));
      settle();
      check("t5_beat_rid", slv_rsp.r.id, (i % 2 == 0) ? 64'hA0 : 64'hA1);
      tick();
    end
    mst_rsp.r_valid = 1'b0;
    drive_ar(8'h77, 32'h0);
    settle();
    check("t5_nonlast_keeps", mst_req.ar.id, 2);
    slv_req.ar_valid = 1'b0;
    drive_r(4'd0, 1'b1, 32'h0); settle();
    check("t5_last0", slv_rsp.r.id, 8'hA0);
    tick();
    drive_r(4'd1, 1'b1, 32'h0); settle();
    check("t5_last1", slv_rsp.r.id, 8'hA1);
    tick();
    mst_rsp.r_valid = 1'b0;
    drive_ar(8'h77, 32'h0);
    settle();
    check("t5_empty", mst_req.ar.id, 0);
    slv_req.ar_valid = 1'b0;

    // Random two-beat reads against an in-order responder, reset mid-stream
    beat    = 0;
    pending = 1'b0;
    cur_id  = '0;
    cur_addr = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (cyc == 200) begin
        rst_n = 1'b0;
        clear_valids();
        q.delete();
        beat    = 0;
        pending = 1'b0;
        tick();
        rst_n = 1'b1;
        drive_ar(8'hEE, 32'h0);
        slv_req.aw_valid = 1'b1;
        slv_req.aw.id    = 8'hEE;
        mst_rsp.ar_ready = 1'b0;
        mst_rsp.aw_ready = 1'b0;
        settle();
        check("t6_rd_empty", mst_req.ar.id, 0);
        check("t6_wr_empty", mst_req.aw.id, 0);
        check("t6_rd_avail", mst_req.ar_valid, 1);
        clear_valids();
        mst_rsp.aw_ready = 1'b1;
      end
      mst_rsp.r_valid = 1'b0;
      if (q.size() > 0 && $urandom_range(0, 1) == 1)
        drive_r(q[0].mid, beat == 1, q[0].addr + 32'(beat));
      if (!pending && $urandom_range(0, 2) != 0) begin
        pending  = 1'b1;
        cur_id   = 8'h10 + 8'($urandom_range(0, 5));
        cur_addr = $urandom & 32'hFFFF_FFF0;
      end
      slv_req.ar_valid  = pending;
      slv_req.ar.id     = cur_id;
      slv_req.ar.p.addr = cur_addr;
      slv_req.ar.p.len  = 8'd1;
      mst_rsp.ar_ready  = ($urandom_range(0, 3) != 0);
      settle();
      if (mst_rsp.r_valid) begin
        check("t6_rid", slv_rsp.r.id, q[0].sid);
        check("t6_rdata", slv_rsp.r.p.data, q[0].addr + 32'(beat));
        if (beat == 1) begin
          void'(q.pop_front());
          beat = 0;
        end else begin
          beat = 1;
        end
      end
      if (mst_req.ar_valid && mst_rsp.ar_ready) begin
        q.push_back('{mst_req.ar.id, cur_id, cur_addr});
        pending = 1'b0;
      end
      tick();
    end
    clear_valids();
    settle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
